// File: rtl/easy_cpu_cpu_mul_combine.sv
// Two-stage combiner of 16x16 partial products into the low 32 bits of a 32x32 product, with tag and valid/ready handshake.
// Optional EASY_CPU_MUL_HIGH_EN adds in_p4/out_hi and a 64-bit final adder. Latency 2 cycles, flush clears both stages.
module easy_cpu_cpu_mul_combine #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
`ifdef EASY_CPU_MUL_HIGH_EN
    input  logic [31:0]      in_p4,
    output logic [31:0]      out_hi,
`endif
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_lo,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic             r_s1_vld;
    logic [32:0]      r_s1_mid;
    logic [31:0]      r_s1_p1;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_vld;
    logic [31:0]      r_out_lo;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_s2_load;
    logic             w_s1_adv;
    logic             w_accept;
    logic [32:0]      w_mid;
    logic [31:0]      w_sum_lo;

    assign w_s2_load = !r_s2_vld || out_ready;
    assign w_s1_adv  = r_s1_vld && w_s2_load;
    // Flush blocks acceptance so nothing slips into the pipeline being cleared.
    assign in_ready  = (!r_s1_vld || w_s1_adv) && !flush;
    assign w_accept  = in_valid && in_ready;
    assign w_mid     = {1'b0, in_p2} + {1'b0, in_p3};

`ifdef EASY_CPU_MUL_HIGH_EN
    logic [31:0] r_s1_p4;
    logic [31:0] r_out_hi;
    logic [63:0] w_sum64;

    assign w_sum64  = {r_s1_p4, r_s1_p1} + {15'd0, r_s1_mid, 16'd0};
    assign w_sum_lo = w_sum64[31:0];
    assign out_hi   = r_out_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_p4  <= '0;
            r_out_hi <= '0;
        end else begin
            if (w_accept)
                r_s1_p4 <= in_p4;
            if (w_s1_adv)
                r_out_hi <= w_sum64[63:32];
        end
    end
`else
    // Only mid[15:0] can reach bits 31:0 once shifted left by 16.
    logic w_unused_mid;
    assign w_unused_mid = &{1'b0, r_s1_mid[32:16]};
    assign w_sum_lo     = r_s1_p1 + {r_s1_mid[15:0], 16'd0};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_mid  <= '0;
            r_s1_p1   <= '0;
            r_s1_tag  <= '0;
            r_s2_vld  <= 1'b0;
            r_out_lo  <= '0;
            r_out_tag <= '0;
        end else begin
            if (flush) begin
                r_s1_vld <= 1'b0;
                r_s2_vld <= 1'b0;
            end else begin
                if (w_accept)
                    r_s1_vld <= 1'b1;
                else if (w_s1_adv)
                    r_s1_vld <= 1'b0;
                if (w_s2_load)
                    r_s2_vld <= r_s1_vld;
            end
            if (w_accept) begin
                r_s1_mid <= w_mid;
                r_s1_p1  <= in_p1;
                r_s1_tag <= in_tag;
            end
            // Output data moves only with a valid entry, so it holds while stalled.
            if (w_s1_adv) begin
                r_out_lo  <= w_sum_lo;
                r_out_tag <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_lo    = r_out_lo;
    assign out_tag   = r_out_tag;
    assign busy      = r_s1_vld || r_s2_vld;

endmodule

// File: tb/tb_easy_cpu_cpu_mul_combine.sv
// Bench for easy_cpu_cpu_mul_combine: directed cases plus a random stream checked against a queue-based product model.
module tb_easy_cpu_cpu_mul_combine;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_p1, in_p2, in_p3, in_p4;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_lo;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
`ifdef EASY_CPU_MUL_HIGH_EN
    logic [31:0]      out_hi;
`endif

    easy_cpu_cpu_mul_combine #(.TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3),
`ifdef EASY_CPU_MUL_HIGH_EN
        .in_p4(in_p4), .out_hi(out_hi),
`endif
        .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lo(out_lo), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      prod;
        logic [TAG_W-1:0] tag;
        int               stamp;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   n_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Full 64-bit product from the three/four partial products.
    function automatic logic [63:0] model(input logic [31:0] p1, input logic [31:0] p2,
                                          input logic [31:0] p3, input logic [31:0] p4);
        logic [63:0] mid;
        mid = 64'(p2) + 64'(p3);
        return {p4, p1} + (mid << 16);
    endfunction

    // A set accepted in cycle c is presented from cycle c+2; at most two sets are in flight.
    always @(negedge clk) begin
        logic exp_vld, exp_rdy;
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            exp_vld = (q.size() > 0) && (cyc - q[0].stamp >= 2);
            exp_rdy = !flush && ((q.size() < 2) || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("busy", busy, q.size() != 0);
            chk("out_valid", out_valid, exp_vld);
            if (exp_vld && out_valid) begin
                chk("out_lo", out_lo, q[0].prod[31:0]);
                chk("out_tag", out_tag, q[0].tag);
`ifdef EASY_CPU_MUL_HIGH_EN
                chk("out_hi", out_hi, q[0].prod[63:32]);
`endif
            end
            if (flush) begin
                q.delete();
            end else begin
                if (exp_vld && out_ready)
                    void'(q.pop_front());
                if (in_valid && exp_rdy) begin
                    e.prod  = model(in_p1, in_p2, in_p3, in_p4);
                    e.tag   = in_tag;
                    e.stamp = cyc;
                    q.push_back(e);
                    n_acc++;
                end
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_set(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                             input logic [31:0] p4, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_p1 = p1; in_p2 = p2; in_p3 = p3; in_p4 = p4; in_tag = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, base, guard;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_p1 = '0; in_p2 = '0; in_p3 = '0; in_p4 = '0; in_tag = '0;

        chk("model_basic", model(32'h8, 32'hA, 32'hC, 32'hF), 64'h0000000F_00160008);
        chk("model_wrap", model(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001),
            64'hFFFFFFFE_00000001);

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_lo", out_lo, 32'h0);
        chk("rst_out_tag", out_tag, '0);
        @(negedge clk); #2; reset = 1'b0;
        next_cycle();
        chk("idle_in_ready", in_ready, 1'b1);

        // Basic result
        drive_set(32'h8, 32'hA, 32'hC, 32'hF, 5'd3);
        next_cycle();
        in_valid = 1'b0;
        chk("basic_lat1_valid", out_valid, 1'b0);
        next_cycle();
        chk("basic_lat2_valid", out_valid, 1'b1);
        chk("basic_lo", out_lo, 32'h00160008);
        chk("basic_tag", out_tag, 5'd3);
`ifdef EASY_CPU_MUL_HIGH_EN
        chk("basic_hi", out_hi, 32'h0000000F);
`endif
        next_cycle();

        // Backpressure: capacity is two sets
        out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive_set($urandom, $urandom, $urandom, $urandom, 5'(i + 10));
            #1;
            cnt += int'(in_ready);
            next_cycle();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_accepted", cnt, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        repeat (3) next_cycle();
        out_ready = 1'b1;
        repeat (4) next_cycle();
        chk("bp_drained", busy, 1'b0);

        // Flush with both stages full and a set offered
        out_ready = 1'b0;
        drive_set(32'h1, 32'h2, 32'h3, 32'h4, 5'd7);
        next_cycle();
        drive_set(32'h5, 32'h6, 32'h7, 32'h8, 5'd8);
        next_cycle();
        drive_set(32'h9, 32'h9, 32'h9, 32'h9, 5'd9);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        next_cycle();
        chk("flush_no_accept", busy, 1'b0);

        // Asynchronous reset with S2 holding a result
        drive_set(32'h8, 32'hA, 32'hC, 32'hF, 5'd5);
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_lo", out_lo, 32'h0);
        chk("arst_busy", busy, 1'b0);
        next_cycle();
        reset = 1'b0;
        out_ready = 1'b1;
        drive_set(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 5'd30);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        chk("post_rst_lat1", out_valid, 1'b0);
        next_cycle();
        chk("post_rst_lat2", out_valid, 1'b1);
        chk("wrap_lo", out_lo, 32'h00000001);
        chk("wrap_tag", out_tag, 5'd30);
`ifdef EASY_CPU_MUL_HIGH_EN
        chk("wrap_hi", out_hi, 32'hFFFFFFFE);
`endif
        next_cycle();

        // Random stream of 100 accepted sets
        base = n_acc;
        guard = 0;
        while ((n_acc - base) < 100 && guard < 3000) begin
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) != 0)
                drive_set($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
            else
                in_valid = 1'b0;
            next_cycle();
            guard++;
        end
        in_valid = 1'b0;
        chk("stream_accepts", n_acc - base, 100);
        out_ready = 1'b1;
        guard = 0;
        while (busy && guard < 20) begin
            next_cycle();
            guard++;
        end
        chk("stream_drain", busy, 1'b0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
